// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential fetches over a req/gnt/rvalid bus and
// buffers the returned words in order for the IF/ID register, honouring stall and redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0100_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out
);

    localparam int BA = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = BW + 1;
    localparam int QA = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [IW-1:0] MAX_INF = IW'(MAX_OUTSTANDING);
    localparam logic [IW-1:0] IONE    = IW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] CONE    = BW'(1);
    localparam logic [BA-1:0] BONE    = BA'(1);
    localparam logic [QA-1:0] QLAST   = QA'(MAX_OUTSTANDING - 1);
    localparam logic [QA-1:0] QONE    = QA'(1);

    logic [31:0]   pc_r;
    logic [IW-1:0] inflight_r;
    logic [IW-1:0] drop_cnt_r;

    logic [31:0]   pcq_mem_r [MAX_OUTSTANDING];
    logic [QA-1:0] pcq_wr_r;
    logic [QA-1:0] pcq_rd_r;

    logic [31:0]   buf_pc_r  [FIFO_DEPTH];
    logic [31:0]   buf_ins_r [FIFO_DEPTH];
    logic [BA-1:0] buf_wr_r;
    logic [BA-1:0] buf_rd_r;
    logic [BW-1:0] count_r;

    logic          valid_r;
    logic [31:0]   pc_out_r;
    logic [31:0]   ins_out_r;

    logic [CW-1:0] credits_s;
    logic          req_s;
    logic          grant_s;
    logic          resp_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   resp_pc_s;
    logic [BW-1:0] remain_s;
    logic [BW-1:0] count_nxt_s;
    logic [BA-1:0] rd_nxt_s;
    logic          valid_nxt_s;
    logic [31:0]   head_pc_nxt_s;
    logic [31:0]   head_ins_nxt_s;

    function automatic logic [QA-1:0] q_inc(input logic [QA-1:0] ptr);
        q_inc = (ptr == QLAST) ? {QA{1'b0}} : ptr + QONE;
    endfunction

    // Request/credit decode and response classification.
    always_comb begin
        credits_s = {{(CW-IW){1'b0}}, inflight_r} + {{(CW-BW){1'b0}}, count_r};
        req_s     = reset_n & ~branch & (inflight_r < MAX_INF) & (credits_s < DEPTH_C);
        grant_s   = req_s & imem_gnt;
        resp_s    = imem_rvalid & (inflight_r != {IW{1'b0}});
        resp_pc_s = pcq_mem_r[pcq_rd_r];
        // Responses owed to a flushed path, or arriving with the redirect, never enter the buffer.
        push_s    = resp_s & ~branch & (drop_cnt_r == {IW{1'b0}});
        pop_s     = valid_r & ~stall & ~branch;
    end

    // Next buffer occupancy and next head value, so the outputs can be registered.
    always_comb begin
        remain_s       = count_r;
        count_nxt_s    = count_r;
        rd_nxt_s       = buf_rd_r;
        valid_nxt_s    = valid_r;
        head_pc_nxt_s  = pc_out_r;
        head_ins_nxt_s = ins_out_r;
        if (branch) begin
            count_nxt_s = {BW{1'b0}};
            rd_nxt_s    = {BA{1'b0}};
            valid_nxt_s = 1'b0;
        end else begin
            if (pop_s) begin
                remain_s = count_r - CONE;
                rd_nxt_s = buf_rd_r + BONE;
            end else begin
                remain_s = count_r;
                rd_nxt_s = buf_rd_r;
            end
            count_nxt_s = push_s ? (remain_s + CONE) : remain_s;
            // An empty buffer lets the incoming word become the head directly.
            if (remain_s != {BW{1'b0}}) begin
                valid_nxt_s    = 1'b1;
                head_pc_nxt_s  = buf_pc_r[rd_nxt_s];
                head_ins_nxt_s = buf_ins_r[rd_nxt_s];
            end else if (push_s) begin
                valid_nxt_s    = 1'b1;
                head_pc_nxt_s  = resp_pc_s;
                head_ins_nxt_s = imem_rdata;
            end else begin
                valid_nxt_s    = 1'b0;
            end
        end
    end

    // Fetch PC, in-flight counter and count of responses still to discard.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_r       <= RESET_PC;
            inflight_r <= {IW{1'b0}};
            drop_cnt_r <= {IW{1'b0}};
        end else begin
            if (branch) begin
                pc_r <= branch_target & 32'hFFFF_FFFC;
            end else if (grant_s) begin
                pc_r <= pc_r + 32'd4;
            end else begin
                pc_r <= pc_r;
            end
            case ({grant_s, resp_s})
                2'b10:   inflight_r <= inflight_r + IONE;
                2'b01:   inflight_r <= inflight_r - IONE;
                default: inflight_r <= inflight_r;
            endcase
            if (branch) begin
                drop_cnt_r <= inflight_r - (resp_s ? IONE : {IW{1'b0}});
            end else if (resp_s && (drop_cnt_r != {IW{1'b0}})) begin
                drop_cnt_r <= drop_cnt_r - IONE;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    // PC tags of granted requests, consumed in order as responses return.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pcq_wr_r <= {QA{1'b0}};
            pcq_rd_r <= {QA{1'b0}};
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                pcq_mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (grant_s) begin
                pcq_mem_r[pcq_wr_r] <= pc_r;
                pcq_wr_r            <= q_inc(pcq_wr_r);
            end
            if (resp_s) begin
                pcq_rd_r <= q_inc(pcq_rd_r);
            end
        end
    end

    // Instruction buffer storage and pointers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_wr_r <= {BA{1'b0}};
            buf_rd_r <= {BA{1'b0}};
            count_r  <= {BW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc_r[i]  <= 32'h0000_0000;
                buf_ins_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (branch) begin
                buf_wr_r <= {BA{1'b0}};
            end else if (push_s) begin
                buf_pc_r[buf_wr_r]  <= resp_pc_s;
                buf_ins_r[buf_wr_r] <= imem_rdata;
                buf_wr_r            <= buf_wr_r + BONE;
            end
            buf_rd_r <= rd_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Head register driving the IF/ID outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_r   <= 1'b0;
            pc_out_r  <= 32'h0000_0000;
            ins_out_r <= 32'h0000_0000;
        end else begin
            valid_r   <= valid_nxt_s;
            pc_out_r  <= head_pc_nxt_s;
            ins_out_r <= head_ins_nxt_s;
        end
    end

    assign imem_req        = req_s;
    assign imem_addr       = pc_r;
    assign valid_out       = valid_r;
    assign pc_out          = pc_out_r;
    assign instruction_out = ins_out_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory model answers with ~addr,
// and every delivered head entry is checked against the expected PC sequence.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branch;
    logic [31:0] branch_target;
    logic        stall;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_pc;
    logic [31:0] hold_pc;
    logic [31:0] pend[$];
    bit          rsp_en;

    fetch_unit #(
        .RESET_PC       (RESET_PC),
        .FIFO_DEPTH     (4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .branch         (branch),
        .branch_target  (branch_target),
        .stall          (stall),
        .valid_out      (valid_out),
        .pc_out         (pc_out),
        .instruction_out(instruction_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check any head entry consumed this cycle, then run the memory model.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        logic [31:0] r;
        #1;
        if (valid_out && !stall && !branch) begin
            check_eq("pop_pc", pc_out, exp_pc);
            check_eq("pop_ins", instruction_out, ~exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        g = imem_req & imem_gnt;
        a = imem_addr;
        @(posedge clock);
        #1;
        if (g) pend.push_back(a);
        if (rsp_en && (pend.size() > 0)) begin
            r           = pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = ~r;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0000_0000;
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        exp_pc        = RESET_PC;
        rsp_en        = 1'b1;
        reset_n       = 1'b0;
        imem_gnt      = 1'b1;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0000_0000;
        branch        = 1'b0;
        branch_target = 32'h0000_0000;
        stall         = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
        check_eq("rst_pc", pc_out, 32'h0000_0000);
        check_eq("rst_ins", instruction_out, 32'h0000_0000);
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_addr", imem_addr, RESET_PC);

        // 1: streaming from reset, one instruction per cycle
        reset_n = 1'b1;
        #1;
        check_eq("t1_c0_req", {31'd0, imem_req}, 32'd1);
        check_eq("t1_c0_addr", imem_addr, RESET_PC);
        check_eq("t1_c0_valid", {31'd0, valid_out}, 32'd0);
        tick();
        check_eq("t1_c1_valid", {31'd0, valid_out}, 32'd0);
        check_eq("t1_c1_addr", imem_addr, 32'h0100_0004);
        tick();
        check_eq("t1_c2_valid", {31'd0, valid_out}, 32'd1);
        check_eq("t1_c2_pc", pc_out, 32'h0100_0000);
        check_eq("t1_c2_ins", instruction_out, 32'hFEFF_FFFF);
        tick();
        repeat (6) tick();
        check_eq("t1_rate", exp_pc, 32'h0100_001C);

        // 2: stall six cycles, credits exhaust, then drain in order
        stall   = 1'b1;
        hold_pc = exp_pc;
        for (int s = 1; s <= 6; s++) begin
            #1;
            check_eq("t2_valid", {31'd0, valid_out}, 32'd1);
            check_eq("t2_pc_hold", pc_out, hold_pc);
            check_eq("t2_ins_hold", instruction_out, ~hold_pc);
            check_eq("t2_req", {31'd0, imem_req}, (s <= 2) ? 32'd1 : 32'd0);
            tick();
        end
        stall = 1'b0;
        for (int s = 0; s < 4; s++) begin
            #1;
            check_eq("t2_drain_valid", {31'd0, valid_out}, 32'd1);
            tick();
        end
        check_eq("t2_drain_count", exp_pc, hold_pc + 32'd16);

        // 3: branch with two requests outstanding
        rsp_en = 1'b0;
        tick();
        tick();
        #1;
        check_eq("t3_req_full", {31'd0, imem_req}, 32'd0);
        tick();
        #1;
        check_eq("t3_req_full2", {31'd0, imem_req}, 32'd0);
        check_eq("t3_drained", {31'd0, valid_out}, 32'd0);
        tick();
        branch        = 1'b1;
        branch_target = 32'h0000_0203;
        rsp_en        = 1'b1;
        #1;
        check_eq("t3_br_req", {31'd0, imem_req}, 32'd0);
        tick();
        branch = 1'b0;
        exp_pc = 32'h0000_0200;
        #1;
        check_eq("t3_b1_addr", imem_addr, 32'h0000_0200);
        check_eq("t3_b1_req", {31'd0, imem_req}, 32'd0);
        check_eq("t3_b1_valid", {31'd0, valid_out}, 32'd0);
        tick();
        check_eq("t3_b2_req", {31'd0, imem_req}, 32'd1);
        check_eq("t3_b2_addr", imem_addr, 32'h0000_0200);
        check_eq("t3_b2_valid", {31'd0, valid_out}, 32'd0);
        tick();
        check_eq("t3_b3_valid", {31'd0, valid_out}, 32'd0);
        tick();
        check_eq("t3_b4_valid", {31'd0, valid_out}, 32'd1);
        check_eq("t3_b4_pc", pc_out, 32'h0000_0200);
        tick();
        repeat (3) tick();

        // 4: branch coincident with a response while stalled
        stall  = 1'b1;
        branch = 1'b1;
        branch_target = 32'h0000_0200;
        #1;
        check_eq("t4_br_req", {31'd0, imem_req}, 32'd0);
        check_eq("t4_br_valid", {31'd0, valid_out}, 32'd1);
        tick();
        stall  = 1'b0;
        branch = 1'b0;
        exp_pc = 32'h0000_0200;
        #1;
        check_eq("t4_b1_valid", {31'd0, valid_out}, 32'd0);
        check_eq("t4_b1_req", {31'd0, imem_req}, 32'd1);
        check_eq("t4_b1_addr", imem_addr, 32'h0000_0200);
        tick();
        check_eq("t4_b2_valid", {31'd0, valid_out}, 32'd0);
        tick();
        check_eq("t4_b3_valid", {31'd0, valid_out}, 32'd1);
        check_eq("t4_b3_pc", pc_out, 32'h0000_0200);
        check_eq("t4_b3_ins", instruction_out, 32'hFFFF_FDFF);
        tick();

        // 5: grant withheld three cycles, then PC steps by 4 per grant
        imem_gnt = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check_eq("t5_req_hold", {31'd0, imem_req}, 32'd1);
            check_eq("t5_addr_hold", imem_addr, 32'h0000_020C);
            tick();
        end
        imem_gnt = 1'b1;
        #1;
        check_eq("t5_g0_addr", imem_addr, 32'h0000_020C);
        tick();
        check_eq("t5_g1_addr", imem_addr, 32'h0000_0210);
        tick();
        check_eq("t5_g2_addr", imem_addr, 32'h0000_0214);
        tick();
        repeat (3) tick();

        // 6: asynchronous reset with a request in flight, stray response afterwards
        reset_n = 1'b0;
        #1;
        check_eq("t6_valid", {31'd0, valid_out}, 32'd0);
        check_eq("t6_pc", pc_out, 32'h0000_0000);
        check_eq("t6_ins", instruction_out, 32'h0000_0000);
        check_eq("t6_req", {31'd0, imem_req}, 32'd0);
        check_eq("t6_addr", imem_addr, RESET_PC);
        pend.delete();
        imem_rvalid = 1'b0;
        tick();
        reset_n     = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        exp_pc      = RESET_PC;
        #1;
        check_eq("t6_c0_req", {31'd0, imem_req}, 32'd1);
        check_eq("t6_c0_addr", imem_addr, RESET_PC);
        tick();
        check_eq("t6_c1_valid", {31'd0, valid_out}, 32'd0);
        tick();
        check_eq("t6_c2_valid", {31'd0, valid_out}, 32'd1);
        check_eq("t6_c2_pc", pc_out, RESET_PC);
        check_eq("t6_c2_ins", instruction_out, ~RESET_PC);
        tick();
        repeat (4) tick();
        check_eq("t6_rate", exp_pc, 32'h0100_0014);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
